// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle main control and the ALU
// control decoder: opcode constants, alu_op operation classes, FSM state
// encoding and the instruction path classes produced by the opcode decoder.
package mips_pkg;

    // Instruction opcodes (4-bit field)
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_SLTI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b0101;
    localparam logic [3:0] OP_SW    = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b0111;
    localparam logic [3:0] OP_BNE   = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1001;
    localparam logic [3:0] OP_J     = 4'b1010;

    // Operation classes handed to the ALU control decoder
    localparam logic [2:0] ALU_RTYPE  = 3'b000;
    localparam logic [2:0] ALU_ADDI   = 3'b001;
    localparam logic [2:0] ALU_ANDI   = 3'b010;
    localparam logic [2:0] ALU_ORI    = 3'b011;
    localparam logic [2:0] ALU_SLTI   = 3'b100;
    localparam logic [2:0] ALU_MEM    = 3'b101;
    localparam logic [2:0] ALU_BRANCH = 3'b110;
    localparam logic [2:0] ALU_LUI    = 3'b111;

    // Main control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Path an instruction takes after DECODE
    typedef enum logic [2:0] {
        CLS_WB      = 3'd0,   // EXEC then WB
        CLS_MEM     = 3'd1,   // EXEC then MEM (lw continues to WB)
        CLS_BRANCH  = 3'd2,   // EXEC resolves the branch
        CLS_JUMP    = 3'd3,   // completes in DECODE
        CLS_ILLEGAL = 3'd4    // flagged in DECODE, never retired
    } op_class_e;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode map: turns a 4-bit opcode into the alu_op class and
// the execution path class used by the main control FSM.
// Ports:
//   opcode_i   [3:0] instruction opcode
//   alu_op_o   [2:0] operation class for the ALU control decoder
//   op_class_o       execution path (WB / MEM / BRANCH / JUMP / ILLEGAL)
module mips_opcode_decode
    import mips_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [2:0] alu_op_o,
    output op_class_e  op_class_o
);

    // Opcode lookup table; unlisted opcodes decode as illegal with alu_op 000
    always_comb begin
        alu_op_o   = ALU_RTYPE;
        op_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_RTYPE: begin alu_op_o = ALU_RTYPE;  op_class_o = CLS_WB;     end
            OP_ADDI:  begin alu_op_o = ALU_ADDI;   op_class_o = CLS_WB;     end
            OP_ANDI:  begin alu_op_o = ALU_ANDI;   op_class_o = CLS_WB;     end
            OP_ORI:   begin alu_op_o = ALU_ORI;    op_class_o = CLS_WB;     end
            OP_SLTI:  begin alu_op_o = ALU_SLTI;   op_class_o = CLS_WB;     end
            OP_LW:    begin alu_op_o = ALU_MEM;    op_class_o = CLS_MEM;    end
            OP_SW:    begin alu_op_o = ALU_MEM;    op_class_o = CLS_MEM;    end
            OP_BEQ:   begin alu_op_o = ALU_BRANCH; op_class_o = CLS_BRANCH; end
            OP_BNE:   begin alu_op_o = ALU_BRANCH; op_class_o = CLS_BRANCH; end
            OP_LUI:   begin alu_op_o = ALU_LUI;    op_class_o = CLS_WB;     end
            OP_J:     begin alu_op_o = ALU_RTYPE;  op_class_o = CLS_JUMP;   end
            default:  begin alu_op_o = ALU_RTYPE;  op_class_o = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// valid/ready instruction handshake, datapath strobes and a retired-
// instruction counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode [3:0]        instruction opcode, captured on accept
//   instr_valid         fetch side offers an instruction
//   instr_ready         high exactly in FETCH
//   zero                ALU zero flag, used in EXEC for branches
//   mem_ack             data memory completion, only observed in MEM
//   alu_op [2:0]        registered operation class for the ALU decoder
//   reg_write, mem_read, mem_write, pc_write, illegal   mutually exclusive strobes
//   retired [CNT_W-1:0] count of completed legal instructions (wraps)
module mips_main_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             zero,
    input  logic             mem_ack,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q,  state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [2:0]       alu_op_q, alu_op_d;
    op_class_e        class_q,  class_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [2:0]       dec_alu_op_s;
    op_class_e        dec_class_s;
    logic             retire_s;
    logic             is_lw_s;
    logic             is_beq_s;

    logic             reg_write_s;
    logic             mem_read_s;
    logic             mem_write_s;
    logic             pc_write_s;
    logic             illegal_s;

    mips_opcode_decode u_decode (
        .opcode_i   (opcode),
        .alu_op_o   (dec_alu_op_s),
        .op_class_o (dec_class_s)
    );

    assign is_lw_s  = (opcode_q == OP_LW);
    assign is_beq_s = (opcode_q == OP_BEQ);

    // Next-state, instruction capture and retire-event logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        alu_op_d = alu_op_q;
        class_d  = class_q;
        retire_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // instr_ready is high here, so instr_valid alone means accept
                if (instr_valid) begin
                    opcode_d = opcode;
                    alu_op_d = dec_alu_op_s;
                    class_d  = dec_class_s;
                    state_d  = ST_DECODE;
                end else begin
                    state_d  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (class_q)
                    CLS_ILLEGAL: state_d = ST_FETCH;
                    CLS_JUMP: begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_BRANCH: begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                    CLS_MEM:    state_d = ST_MEM;
                    default:    state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // The ack cycle is the last MEM cycle; sw retires here
                if (mem_ack) begin
                    if (is_lw_s) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                state_d  = ST_FETCH;
                retire_s = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Retired counter next value, wrapping naturally at 2^CNT_W
    always_comb begin
        if (retire_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // State, captured instruction and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 4'b0000;
            alu_op_q  <= 3'b000;
            class_q   <= CLS_WB;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            alu_op_q  <= alu_op_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

    // Moore strobe decode from state and captured instruction only; the
    // branch strobe additionally follows the ALU zero flag during EXEC
    always_comb begin
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        pc_write_s  = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            ST_DECODE: begin
                if (class_q == CLS_ILLEGAL) begin
                    illegal_s = 1'b1;
                end else if (class_q == CLS_JUMP) begin
                    pc_write_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            ST_EXEC: begin
                if (class_q == CLS_BRANCH) begin
                    pc_write_s = is_beq_s ? zero : !zero;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            ST_MEM: begin
                if (is_lw_s) begin
                    mem_read_s = 1'b1;
                end else begin
                    mem_write_s = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
            end
            default: begin
                reg_write_s = 1'b0;
            end
        endcase
    end

    assign instr_ready = (state_q == ST_FETCH);
    assign alu_op      = alu_op_q;
    assign retired     = retired_q;
    assign reg_write   = reg_write_s;
    assign mem_read    = mem_read_s;
    assign mem_write   = mem_write_s;
    assign pc_write    = pc_write_s;
    assign illegal     = illegal_s;

endmodule

// File: tb/tb_mips_main_control.sv
// Directed self-checking bench for mips_main_control. A narrow counter
// (CNT_W=4) lets the wrap case be reached with a handful of instructions.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mips_main_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       opcode;
    logic             instr_valid;
    logic             instr_ready;
    logic             zero;
    logic             mem_ack;
    logic [2:0]       alu_op;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             pc_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] exp_retired = '0;

    mips_main_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .illegal     (illegal),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; opcode = 4'b0000; instr_valid = 1'b0; zero = 1'b0; mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if ({reg_write, mem_read, mem_write, pc_write, illegal} !== 5'b00000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {reg_write, mem_read, mem_write, pc_write, illegal}); end
        checks++; if (alu_op !== 3'b000) begin errors++; $display("FAIL reset_alu_op: got %b expected 000", alu_op); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", instr_ready); end
    endtask

    task automatic test_rtype();
        opcode = 4'b0000; instr_valid = 1'b1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rtype_ready_c0: got %b expected 1", instr_ready); end
        step(); // DECODE
        checks++; if (alu_op !== 3'b000) begin errors++; $display("FAIL rtype_alu_op: got %b expected 000", alu_op); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rtype_ready_c1: got %b expected 0", instr_ready); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rtype_wb_c1: got %b expected 0", reg_write); end
        step(); // EXEC
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rtype_wb_c2: got %b expected 0", reg_write); end
        step(); // WB
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL rtype_wb_c3: got %b expected 1", reg_write); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rtype_retired_c3: got %0d expected 0", retired); end
        step(); // FETCH
        exp_retired = exp_retired + 1'b1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rtype_ready_c4: got %b expected 1", instr_ready); end
        checks++; if (retired !== 4'd1) begin errors++; $display("FAIL rtype_retired_c4: got %0d expected 1", retired); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rtype_wb_c4: got %b expected 0", reg_write); end
        instr_valid = 1'b0;
    endtask

    task automatic test_lw();
        int rd_cnt = 0, wr_cnt = 0, wb_cnt = 0, wb_cyc = 0, alu_bad = 0;
        opcode = 4'b0101; instr_valid = 1'b1; mem_ack = 1'b1;
        step();
        instr_valid = 1'b0; opcode = 4'b1111;
        for (int c = 1; c <= 7; c++) begin
            // ack high in DECODE/EXEC must be ignored; 3 wait cycles then ack
            mem_ack = (c == 1 || c == 2 || c == 6);
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (reg_write) begin wb_cnt++; wb_cyc = c; end
            if (alu_op !== 3'b101) alu_bad++;
            step();
        end
        mem_ack = 1'b0;
        exp_retired = exp_retired + 1'b1;
        checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL lw_mem_read_cycles: got %0d expected 4", rd_cnt); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL lw_mem_write_cycles: got %0d expected 0", wr_cnt); end
        checks++; if (wb_cnt !== 1) begin errors++; $display("FAIL lw_reg_write_count: got %0d expected 1", wb_cnt); end
        checks++; if (wb_cyc !== 7) begin errors++; $display("FAIL lw_reg_write_cycle: got %0d expected 7", wb_cyc); end
        checks++; if (alu_bad !== 0) begin errors++; $display("FAIL lw_alu_op: got %0d bad cycles expected 0", alu_bad); end
        checks++; if (alu_op !== 3'b101) begin errors++; $display("FAIL lw_alu_op_hold: got %b expected 101", alu_op); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL lw_ready: got %b expected 1", instr_ready); end
        checks++; if (retired !== 4'd2) begin errors++; $display("FAIL lw_retired: got %0d expected 2", retired); end
    endtask

    task automatic test_branch();
        logic [3:0] ops [3]   = '{4'b0111, 4'b1000, 4'b1000};
        logic       zs  [3]   = '{1'b1, 1'b1, 1'b0};
        int         exp_p [3] = '{1, 0, 1};
        logic [CNT_W-1:0] exp_r [3] = '{4'd3, 4'd4, 4'd5};
        for (int i = 0; i < 3; i++) begin
            int pulses = 0;
            int pcyc = 0;
            opcode = ops[i]; zero = zs[i]; instr_valid = 1'b1;
            step();
            instr_valid = 1'b0;
            checks++; if (alu_op !== 3'b110) begin errors++; $display("FAIL branch%0d_alu_op: got %b expected 110", i, alu_op); end
            for (int c = 1; c <= 2; c++) begin
                if (pc_write) begin pulses++; pcyc = c; end
                step();
            end
            exp_retired = exp_retired + 1'b1;
            checks++; if (pulses !== exp_p[i]) begin errors++; $display("FAIL branch%0d_pc_write: got %0d pulses expected %0d", i, pulses, exp_p[i]); end
            if (exp_p[i] == 1) begin
                checks++; if (pcyc !== 2) begin errors++; $display("FAIL branch%0d_pc_cycle: got %0d expected 2", i, pcyc); end
            end
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL branch%0d_ready: got %b expected 1", i, instr_ready); end
            checks++; if (retired !== exp_r[i]) begin errors++; $display("FAIL branch%0d_retired: got %0d expected %0d", i, retired, exp_r[i]); end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        opcode = 4'b1100; instr_valid = 1'b1;
        step(); // DECODE
        instr_valid = 1'b0;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", illegal); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL illegal_pc_write: got %b expected 0", pc_write); end
        step(); // FETCH
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_width: got %b expected 0", illegal); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", instr_ready); end
        checks++; if (retired !== 4'd5) begin errors++; $display("FAIL illegal_retired: got %0d expected 5", retired); end
    endtask

    task automatic test_alu_ops();
        logic [3:0] ops  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1001};
        logic [2:0] alus [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        for (int i = 0; i < 6; i++) begin
            int wb = 0;
            opcode = ops[i]; instr_valid = 1'b1;
            step();
            instr_valid = 1'b0; opcode = 4'b1100;
            checks++; if (alu_op !== alus[i]) begin errors++; $display("FAIL aluop_%b: got %b expected %b", ops[i], alu_op, alus[i]); end
            for (int c = 1; c <= 3; c++) begin
                if (reg_write) wb++;
                step();
            end
            exp_retired = exp_retired + 1'b1;
            checks++; if (wb !== 1) begin errors++; $display("FAIL aluop_%b_wb: got %0d expected 1", ops[i], wb); end
            checks++; if (retired !== exp_retired) begin errors++; $display("FAIL aluop_%b_retired: got %0d expected %0d", ops[i], retired, exp_retired); end
            checks++; if (alu_op !== alus[i]) begin errors++; $display("FAIL aluop_%b_hold: got %b expected %b", ops[i], alu_op, alus[i]); end
        end
    endtask

    task automatic test_jump_preload();
        int pulses = 0, n = 0;
        for (int k = 0; k < 16 && exp_retired != 4'hF; k++) begin
            opcode = 4'b1010; instr_valid = 1'b1;
            step();
            instr_valid = 1'b0;
            if (pc_write) pulses++;
            step();
            exp_retired = exp_retired + 1'b1;
            n++;
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL jump_pc_write: got %0d expected 4", pulses); end
        checks++; if (n !== 4) begin errors++; $display("FAIL jump_count: got %0d expected 4", n); end
        checks++; if (retired !== 4'hF) begin errors++; $display("FAIL jump_retired: got %0d expected 15", retired); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL jump_ready: got %b expected 1", instr_ready); end
    endtask

    task automatic test_wrap_sw();
        int wr = 0, wb = 0;
        opcode = 4'b0110; instr_valid = 1'b1; mem_ack = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (mem_write) wr++;
            if (reg_write) wb++;
            step();
        end
        exp_retired = exp_retired + 1'b1;
        mem_ack = 1'b0;
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL sw_wrap_retired: got %0d expected 0", retired); end
        checks++; if (wr !== 1) begin errors++; $display("FAIL sw_mem_write: got %0d expected 1", wr); end
        checks++; if (wb !== 0 || reg_write !== 1'b0) begin errors++; $display("FAIL sw_no_reg_write: got %0d expected 0", wb); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b expected 1", instr_ready); end
    endtask

    task automatic test_reset_mid_mem();
        opcode = 4'b0001; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step(); step();
        exp_retired = exp_retired + 1'b1;
        checks++; if (retired !== 4'd1) begin errors++; $display("FAIL rst_pre_retired: got %0d expected 1", retired); end
        opcode = 4'b0110; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step(); // first MEM cycle, no ack
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mem_write_c3: got %b expected 1", mem_write); end
        step();
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mem_write_c4: got %b expected 1", mem_write); end
        #2 rst_n = 1'b0;
        #1;
        exp_retired = '0;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_async_mem_write: got %b expected 0", mem_write); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_async_fetch: got %b expected 1", instr_ready); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rst_async_retired: got %0d expected 0", retired); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; opcode = 4'b1001; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_first_accept: got ready %b expected 0", instr_ready); end
        checks++; if (alu_op !== 3'b111) begin errors++; $display("FAIL rst_first_alu_op: got %b expected 111", alu_op); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rst_post_retired: got %0d expected 0", retired); end
        step(); step();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL rst_lui_wb: got %b expected 1", reg_write); end
        step();
        exp_retired = exp_retired + 1'b1;
        checks++; if (retired !== 4'd1) begin errors++; $display("FAIL rst_lui_retired: got %0d expected 1", retired); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_branch();
        test_illegal();
        test_alu_ops();
        test_jump_preload();
        test_wrap_sw();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
